// File: rtl/mem_port_arb_pkg.sv
// ---------------------------------------------------------------------------
// mem_port_arb_pkg
//   Shared definitions for the memory port arbiter and the fetch stage.
//   - NOP_INSTR : instruction word returned on a read-data port that does
//                 not own the current memory response (and during reset).
//   - owner_t   : which requester owns the read data coming back from the
//                 single-port synchronous memory one cycle after the access.
//   - next_owner: maps this cycle's grant to the owner of next cycle's mem_q.
// ---------------------------------------------------------------------------
package mem_port_arb_pkg;

  localparam logic [31:0] NOP_INSTR = 32'h3C00_0000;

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_IF   = 2'd1,
    OWN_DM   = 2'd2
  } owner_t;

  // A data-port write produces no read data, so it leaves the owner at NONE.
  function automatic owner_t next_owner(input logic if_gnt,
                                        input logic dm_gnt,
                                        input logic dm_we);
    owner_t own;
    own = OWN_NONE;
    if (if_gnt) begin
      own = OWN_IF;
    end else if (dm_gnt && !dm_we) begin
      own = OWN_DM;
    end
    return own;
  endfunction

endpackage : mem_port_arb_pkg

// File: rtl/mem_port_arb_arb_fair2.sv
// ---------------------------------------------------------------------------
// arb_fair2
//   Two-requester arbiter: the data port wins by default, but after DM_MAX
//   consecutive data grants while fetch is waiting, fetch is granted once.
//
//   Ports
//     clk     in   clock, rising edge
//     rst     in   asynchronous reset, active-low
//     if_req  in   fetch request
//     dm_req  in   data-port request
//     if_gnt  out  fetch grant for this cycle (combinational)
//     dm_gnt  out  data-port grant for this cycle (combinational)
// ---------------------------------------------------------------------------
module arb_fair2 #(
  parameter int DM_MAX = 3
) (
  input  logic clk,
  input  logic rst,
  input  logic if_req,
  input  logic dm_req,
  output logic if_gnt,
  output logic dm_gnt
);

  localparam int CNT_W = (DM_MAX < 1) ? 1 : $clog2(DM_MAX + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DM_MAX);

  logic [CNT_W-1:0] dm_cnt;
  logic             fetch_due;

  // Fetch has waited through DM_MAX data grants and must go next.
  assign fetch_due = (dm_cnt == CNT_MAX);

  // No grants are issued while reset is held, so the memory outputs stay
  // at their reset values until release.
  assign if_gnt = rst & if_req & (~dm_req | fetch_due);
  assign dm_gnt = rst & dm_req & ~if_gnt;

  // dm_cnt only counts data grants that made fetch wait; it stops at
  // DM_MAX because the next cycle with fetch still waiting grants fetch.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      dm_cnt <= '0;
    end else if (!if_req || if_gnt) begin
      dm_cnt <= '0;
    end else if (dm_gnt && (dm_cnt != CNT_MAX)) begin
      dm_cnt <= dm_cnt + CNT_W'(1);
    end
  end

endmodule : arb_fair2

// File: rtl/mem_port_arb.sv
// ---------------------------------------------------------------------------
// mem_port_arb
//   Shares one single-port synchronous memory between the instruction fetch
//   port and the data port. One access per cycle; the grant is decided
//   combinationally by arb_fair2, the memory address/write/data are muxed
//   from the winner, and the owner of the read is registered so that the
//   memory response (mem_q, one cycle later) is routed to the right port.
//
//   Ports
//     clk, rst            clock (rising edge), async active-low reset
//     if_req, if_addr     fetch read request and word address
//     dm_req, dm_we       data-port request, write enable (1 = write)
//     dm_addr, dm_wdata   data-port word address and write data
//     if_gnt, dm_gnt      combinational grants for this cycle
//     if_stall_o          fetch requested but not granted this cycle
//     if_rvalid, if_rdata fetch read response (NOP when not owner)
//     dm_rvalid, dm_rdata data read response (NOP when not owner)
//     mem_a, mem_w, mem_d memory address, write enable, write data
//     mem_q               memory read data, valid one cycle after mem_a
// ---------------------------------------------------------------------------
module mem_port_arb
  import mem_port_arb_pkg::*;
#(
  parameter int ADDR   = 16,
  parameter int WORD   = 32,
  parameter int DM_MAX = 3
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            if_req,
  input  logic [ADDR-1:0] if_addr,
  input  logic            dm_req,
  input  logic            dm_we,
  input  logic [ADDR-1:0] dm_addr,
  input  logic [WORD-1:0] dm_wdata,
  output logic            if_gnt,
  output logic            dm_gnt,
  output logic            if_rvalid,
  output logic            dm_rvalid,
  output logic [WORD-1:0] if_rdata,
  output logic [WORD-1:0] dm_rdata,
  output logic            if_stall_o,
  output logic [ADDR-1:0] mem_a,
  output logic            mem_w,
  output logic [WORD-1:0] mem_d,
  input  logic [WORD-1:0] mem_q
);

  localparam logic [WORD-1:0] NOP_W = WORD'(NOP_INSTR);

  logic [ADDR-1:0] a_hold;
  logic [WORD-1:0] d_hold;
  owner_t          owner_p1;

  arb_fair2 #(
    .DM_MAX (DM_MAX)
  ) u_arb (
    .clk    (clk),
    .rst    (rst),
    .if_req (if_req),
    .dm_req (dm_req),
    .if_gnt (if_gnt),
    .dm_gnt (dm_gnt)
  );

  assign if_stall_o = if_req & ~if_gnt;

  // ---- stage p0: memory request from the granted port ----
  // mem_d follows the data port whenever it is granted (the memory ignores
  // it on reads); fetch grants and idle cycles keep the last value.
  always_comb begin
    mem_a = a_hold;
    mem_d = d_hold;
    mem_w = 1'b0;
    if (dm_gnt) begin
      mem_a = dm_addr;
      mem_d = dm_wdata;
      mem_w = dm_we;
    end else if (if_gnt) begin
      mem_a = if_addr;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      a_hold <= '0;
      d_hold <= '0;
    end else begin
      if (dm_gnt || if_gnt) begin
        a_hold <= mem_a;
      end
      if (dm_gnt) begin
        d_hold <= dm_wdata;
      end
    end
  end

  // ---- stage p1: read owner for the response on mem_q ----
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      owner_p1 <= OWN_NONE;
    end else begin
      owner_p1 <= next_owner(if_gnt, dm_gnt, dm_we);
    end
  end

  always_comb begin
    if_rvalid = (owner_p1 == OWN_IF);
    dm_rvalid = (owner_p1 == OWN_DM);
    if_rdata  = if_rvalid ? mem_q : NOP_W;
    dm_rdata  = dm_rvalid ? mem_q : NOP_W;
  end

endmodule : mem_port_arb

// File: tb/tb_mem_port_arb.sv
// ---------------------------------------------------------------------------
// tb_mem_port_arb
//   Bench for mem_port_arb: a synchronous memory model answers the DUT, a
//   cycle-level reference model (fairness streak, shadow memory, pending
//   read) checks every output on every falling edge, and a few directed
//   sequences pin exact literal values.
// ---------------------------------------------------------------------------
module tb_mem_port_arb;

  localparam int ADDR   = 16;
  localparam int WORD   = 32;
  localparam int DM_MAX = 3;
  localparam logic [31:0] NOP = 32'h3C00_0000;

  logic            clk = 1'b0;
  logic            rst = 1'b0;
  logic            if_req = 1'b0;
  logic [ADDR-1:0] if_addr = '0;
  logic            dm_req = 1'b0;
  logic            dm_we = 1'b0;
  logic [ADDR-1:0] dm_addr = '0;
  logic [WORD-1:0] dm_wdata = '0;
  logic            if_gnt, dm_gnt, if_rvalid, dm_rvalid, if_stall_o, mem_w;
  logic [WORD-1:0] if_rdata, dm_rdata, mem_d;
  logic [ADDR-1:0] mem_a;
  logic [WORD-1:0] mem_q = '0;

  int errors = 0;
  int checks = 0;

  mem_port_arb #(.ADDR(ADDR), .WORD(WORD), .DM_MAX(DM_MAX)) dut (
    .clk        (clk),
    .rst        (rst),
    .if_req     (if_req),
    .if_addr    (if_addr),
    .dm_req     (dm_req),
    .dm_we      (dm_we),
    .dm_addr    (dm_addr),
    .dm_wdata   (dm_wdata),
    .if_gnt     (if_gnt),
    .dm_gnt     (dm_gnt),
    .if_rvalid  (if_rvalid),
    .dm_rvalid  (dm_rvalid),
    .if_rdata   (if_rdata),
    .dm_rdata   (dm_rdata),
    .if_stall_o (if_stall_o),
    .mem_a      (mem_a),
    .mem_w      (mem_w),
    .mem_d      (mem_d),
    .mem_q      (mem_q)
  );

  always #5 clk = ~clk;

  // Memory contents start as a recognisable pattern: word a holds A5A5_aaaa.
  function automatic logic [31:0] init_word(input int a);
    return 32'hA5A5_0000 | (a & 32'hFFFF);
  endfunction

  logic [WORD-1:0] sram   [0:(1<<ADDR)-1];
  logic [WORD-1:0] shadow [0:(1<<ADDR)-1];

  initial begin
    for (int i = 0; i < (1 << ADDR); i++) begin
      sram[i]   = init_word(i);
      shadow[i] = init_word(i);
    end
  end

  // Single-port synchronous memory: read data appears the cycle after.
  always @(posedge clk) begin
    if (mem_w) sram[mem_a] <= mem_d;
    mem_q <= sram[mem_a];
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  // ---------------- reference model and per-cycle compare ----------------
  int              streak;     // data grants in a row while fetch waited
  int              pend_own;   // 0 none, 1 fetch, 2 data
  logic [WORD-1:0] pend_data;
  logic [ADDR-1:0] last_a;

  initial begin
    logic e_if, e_dm;
    logic [ADDR-1:0] e_a;
    streak = 0; pend_own = 0; pend_data = '0; last_a = '0;
    forever begin
      @(negedge clk);
      if (!rst) begin
        chk("rst_if_rvalid", {31'b0, if_rvalid}, 32'd0);
        chk("rst_dm_rvalid", {31'b0, dm_rvalid}, 32'd0);
        chk("rst_if_rdata", if_rdata, NOP);
        chk("rst_dm_rdata", dm_rdata, NOP);
        chk("rst_mem_w", {31'b0, mem_w}, 32'd0);
        chk("rst_mem_a", {16'b0, mem_a}, 32'd0);
        chk("rst_mem_d", mem_d, 32'd0);
        streak = 0; pend_own = 0; last_a = '0;
      end else begin
        e_if = if_req && (!dm_req || streak == DM_MAX);
        e_dm = dm_req && !e_if;
        e_a  = e_dm ? dm_addr : (e_if ? if_addr : last_a);
        chk("if_gnt", {31'b0, if_gnt}, {31'b0, e_if});
        chk("dm_gnt", {31'b0, dm_gnt}, {31'b0, e_dm});
        chk("if_stall", {31'b0, if_stall_o}, {31'b0, if_req && !e_if});
        chk("mem_a", {16'b0, mem_a}, {16'b0, e_a});
        chk("mem_w", {31'b0, mem_w}, {31'b0, e_dm && dm_we});
        if (e_dm) chk("mem_d", mem_d, dm_wdata);
        chk("if_rvalid", {31'b0, if_rvalid}, {31'b0, pend_own == 1});
        chk("dm_rvalid", {31'b0, dm_rvalid}, {31'b0, pend_own == 2});
        chk("if_rdata", if_rdata, (pend_own == 1) ? pend_data : NOP);
        chk("dm_rdata", dm_rdata, (pend_own == 2) ? pend_data : NOP);
        // advance the model by one cycle
        pend_own  = e_if ? 1 : ((e_dm && !dm_we) ? 2 : 0);
        pend_data = shadow[e_a];
        if (e_dm && dm_we) shadow[dm_addr] = dm_wdata;
        last_a = e_a;
        if (!if_req || e_if) streak = 0;
        else if (e_dm) streak++;
      end
    end
  end

  // ---------------- stimulus with directed literal checks ----------------
  task automatic drive(input logic r, input logic ir, input logic [ADDR-1:0] ia,
                       input logic dr, input logic dw, input logic [ADDR-1:0] da,
                       input logic [WORD-1:0] dd);
    @(posedge clk); #1;
    rst = r; if_req = ir; if_addr = ia;
    dm_req = dr; dm_we = dw; dm_addr = da; dm_wdata = dd;
    @(negedge clk); #1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    // reset state
    repeat (2) @(posedge clk);
    @(negedge clk); #1;
    chk("d_rst_if_rvalid", {31'b0, if_rvalid}, 32'd0);
    chk("d_rst_if_rdata", if_rdata, 32'h3C00_0000);
    chk("d_rst_mem_a", {16'b0, mem_a}, 32'd0);

    // fetch only, granted on the first edge after release
    drive(1, 1, 16'h0010, 0, 0, 16'h0, 32'h0);
    chk("d_if_gnt", {31'b0, if_gnt}, 32'd1);
    chk("d_if_mem_a", {16'b0, mem_a}, 32'h0010);
    drive(1, 0, 16'h0, 0, 0, 16'h0, 32'h0);
    chk("d_if_rvalid", {31'b0, if_rvalid}, 32'd1);
    chk("d_if_rdata", if_rdata, 32'hA5A5_0010);

    // data write then read back
    drive(1, 0, 16'h0, 1, 1, 16'h0100, 32'hDEAD_BEEF);
    chk("d_wr_mem_w", {31'b0, mem_w}, 32'd1);
    drive(1, 0, 16'h0, 1, 0, 16'h0100, 32'h0);
    chk("d_wr_no_rvalid", {31'b0, dm_rvalid}, 32'd0);
    drive(1, 0, 16'h0, 0, 0, 16'h0, 32'h0);
    chk("d_rd_rvalid", {31'b0, dm_rvalid}, 32'd1);
    chk("d_rd_rdata", dm_rdata, 32'hDEAD_BEEF);

    // both requesting for 8 cycles: DM DM DM IF DM DM DM IF
    for (int i = 0; i < 8; i++) begin
      drive(1, 1, ADDR'(16'h0020 + i), 1, 0, ADDR'(16'h0030 + i), 32'h0);
      chk($sformatf("d_fair_dm%0d", i), {31'b0, dm_gnt}, {31'b0, (i % 4) != 3});
      chk($sformatf("d_fair_if%0d", i), {31'b0, if_gnt}, {31'b0, (i % 4) == 3});
      chk($sformatf("d_fair_stall%0d", i), {31'b0, if_stall_o}, {31'b0, (i % 4) != 3});
    end
    drive(1, 0, 16'h0, 0, 0, 16'h0, 32'h0);

    // fetch and data write together
    drive(1, 1, 16'h0040, 1, 1, 16'h0041, 32'h1234_5678);
    chk("d_fw_dm_gnt", {31'b0, dm_gnt}, 32'd1);
    chk("d_fw_mem_w", {31'b0, mem_w}, 32'd1);
    chk("d_fw_stall", {31'b0, if_stall_o}, 32'd1);
    drive(1, 0, 16'h0, 0, 0, 16'h0, 32'h0);
    chk("d_fw_no_ifv", {31'b0, if_rvalid}, 32'd0);
    chk("d_fw_no_dmv", {31'b0, dm_rvalid}, 32'd0);

    // reset right after a fetch grant discards the pending read
    drive(1, 1, 16'h0044, 0, 0, 16'h0, 32'h0);
    chk("d_rs_if_gnt", {31'b0, if_gnt}, 32'd1);
    drive(0, 0, 16'h0, 0, 0, 16'h0, 32'h0);
    chk("d_rs_if_rvalid", {31'b0, if_rvalid}, 32'd0);
    chk("d_rs_if_rdata", if_rdata, 32'h3C00_0000);
    drive(0, 0, 16'h0, 0, 0, 16'h0, 32'h0);
    drive(1, 0, 16'h0, 0, 0, 16'h0, 32'h0);
    chk("d_rs_after_ifv", {31'b0, if_rvalid}, 32'd0);
    drive(1, 0, 16'h0, 0, 0, 16'h0, 32'h0);
    chk("d_rs_after2_ifv", {31'b0, if_rvalid}, 32'd0);

    // randomized traffic on a small address window, with occasional resets
    for (int n = 0; n < 3000; n++) begin
      logic r;
      r = rst ? ($urandom_range(0, 249) != 0) : 1'b1;
      drive(r, ($urandom_range(0, 9) < 7), ADDR'($urandom_range(0, 63)),
            ($urandom_range(0, 9) < 7), $urandom_range(0, 1) == 1,
            ADDR'($urandom_range(0, 63)), $urandom);
    end
    drive(1, 0, 16'h0, 0, 0, 16'h0, 32'h0);
    drive(1, 0, 16'h0, 0, 0, 16'h0, 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule : tb_mem_port_arb
